// File: rtl/axi_tdd_pkg.sv
// Shared types for the TDD engine: frame counter FSM states seen by the sync controller.
package axi_tdd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    WAITING = 2'd2,
    RUNNING = 2'd3
  } state_t;

endpackage

// File: rtl/axi_tdd_sync_ctrl.sv
// Merges external, internal periodic and software sync sources into one gated tdd_sync strobe
// for the TDD frame counter, and counts events rejected by the gate.
module axi_tdd_sync_ctrl
  import axi_tdd_pkg::*;
#(
  parameter int SYNC_COUNT_WIDTH = 64,
  parameter int DROP_COUNT_WIDTH = 16,
  parameter bit SYNC_EXT_CDC     = 1'b1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        tdd_enable,
  input  logic                        tdd_sync_rst,
  input  logic                        sync_ext_en,
  input  logic                        sync_int_en,
  input  logic                        sync_soft,
  input  logic [SYNC_COUNT_WIDTH-1:0] asy_sync_period,
  input  logic                        sync_in,
  input  state_t                      tdd_cstate,
  output logic                        tdd_sync,
  output logic [DROP_COUNT_WIDTH-1:0] sync_drop_count
);

  typedef enum logic {
    ST_OFF    = 1'b0,
    ST_ACTIVE = 1'b1
  } sync_state_t;

  sync_state_t state;
  sync_state_t state_next;

  logic                        en_d;
  logic                        en_rise;
  logic                        sync_s;
  logic                        sync_d;
  logic                        ext_event;
  logic                        int_run;
  logic                        int_hit;
  logic                        int_event;
  logic                        sync_event;
  logic                        gate_open;
  logic                        drop_hit;
  logic [SYNC_COUNT_WIDTH-1:0] period_reg;
  logic [SYNC_COUNT_WIDTH-1:0] int_cnt;
  logic [DROP_COUNT_WIDTH-1:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_OFF;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_OFF:    if (tdd_enable)  state_next = ST_ACTIVE;
      ST_ACTIVE: if (!tdd_enable) state_next = ST_OFF;
      default:   state_next = ST_OFF;
    endcase
  end

  // Synchronizer and edge history reset high so a pin held high through reset is not an edge.
  generate
    if (SYNC_EXT_CDC) begin : g_cdc
      logic [1:0] sync_ff;
      always_ff @(posedge clk) begin
        if (!resetn) begin
          sync_ff <= 2'b11;
        end else begin
          sync_ff <= {sync_ff[0], sync_in};
        end
      end
      assign sync_s = sync_ff[1];
    end else begin : g_no_cdc
      assign sync_s = sync_in;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_d <= 1'b1;
      en_d   <= 1'b0;
    end else begin
      sync_d <= sync_s;
      en_d   <= tdd_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      period_reg <= '0;
    end else if (tdd_enable) begin
      period_reg <= asy_sync_period;
    end
  end

  assign en_rise   = tdd_enable & ~en_d;
  assign ext_event = sync_ext_en & sync_s & ~sync_d;
  assign int_run   = (state == ST_ACTIVE) & sync_int_en & (period_reg != '0);
  // Compare with >= so a shrinking period still wraps instead of running to full scale.
  assign int_hit   = int_cnt >= (period_reg - SYNC_COUNT_WIDTH'(1));
  assign int_event = int_run & int_hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      int_cnt <= '0;
    end else if (!int_run || en_rise) begin
      int_cnt <= '0;
    end else if (ext_event && sync_int_en) begin
      int_cnt <= '0;
    end else if (int_hit) begin
      int_cnt <= '0;
    end else begin
      int_cnt <= int_cnt + SYNC_COUNT_WIDTH'(1);
    end
  end

  assign sync_event = ext_event | int_event | sync_soft;
  assign gate_open  = tdd_enable & (tdd_sync_rst | (tdd_cstate == ARMED));
  assign drop_hit   = sync_event & tdd_enable & ~gate_open;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (en_rise) begin
      drop_cnt <= '0;
    end else if (drop_hit && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tdd_sync <= 1'b0;
    end else begin
      tdd_sync <= sync_event & gate_open;
    end
  end

  assign sync_drop_count = drop_cnt;

endmodule

// File: tb/tb_axi_tdd_sync_ctrl.sv
// Self-checking bench for axi_tdd_sync_ctrl: directed scenarios plus random traffic against
// a cycle-indexed model that derives internal syncs from a phase anchor and modular arithmetic.
module tb_axi_tdd_sync_ctrl;
  import axi_tdd_pkg::*;

  localparam int SW = 16;
  localparam int DW = 3;
  localparam int DROP_MAX = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          tdd_enable = 1'b0;
  logic          tdd_sync_rst = 1'b0;
  logic          sync_ext_en = 1'b0;
  logic          sync_int_en = 1'b0;
  logic          sync_soft = 1'b0;
  logic [SW-1:0] asy_sync_period = '0;
  logic          sync_in = 1'b0;
  state_t        tdd_cstate = IDLE;
  logic          tdd_sync;
  logic [DW-1:0] sync_drop_count;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int anchor = 0;
  int m_period = 0;
  int m_drop = 0;
  bit m_active = 1'b0;
  bit m_en_d = 1'b0;
  bit exp_sync = 1'b0;
  bit pin_hist[$] = '{1'b1, 1'b1, 1'b1};

  int pulses = 0;
  int pulse_q[$];

  axi_tdd_sync_ctrl #(
    .SYNC_COUNT_WIDTH(SW),
    .DROP_COUNT_WIDTH(DW),
    .SYNC_EXT_CDC(1'b1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .tdd_enable(tdd_enable),
    .tdd_sync_rst(tdd_sync_rst),
    .sync_ext_en(sync_ext_en),
    .sync_int_en(sync_int_en),
    .sync_soft(sync_soft),
    .asy_sync_period(asy_sync_period),
    .sync_in(sync_in),
    .tdd_cstate(tdd_cstate),
    .tdd_sync(tdd_sync),
    .sync_drop_count(sync_drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // pin_hist holds sync_in of the last three cycles, oldest first.
  task automatic modelStep();
    bit ext_ev;
    bit int_ev;
    bit ev;
    bit gate;
    bit rise;
    bit counting;
    if (!resetn) begin
      exp_sync = 1'b0;
      m_drop   = 0;
      m_period = 0;
      m_active = 1'b0;
      m_en_d   = 1'b0;
      anchor   = cyc + 1;
      pin_hist = '{1'b1, 1'b1, 1'b1};
    end else begin
      ext_ev   = sync_ext_en && pin_hist[1] && !pin_hist[0];
      counting = m_active && sync_int_en && (m_period != 0);
      int_ev   = counting && (((cyc - anchor) % m_period) == m_period - 1);
      ev       = ext_ev || int_ev || sync_soft;
      gate     = tdd_enable && (tdd_sync_rst || tdd_cstate == ARMED);
      rise     = tdd_enable && !m_en_d;
      exp_sync = ev && gate;
      if (rise) m_drop = 0;
      else if (ev && tdd_enable && !gate && m_drop < DROP_MAX) m_drop++;
      if (!counting || rise || (ext_ev && sync_int_en)) anchor = cyc + 1;
      if (tdd_enable) m_period = int'(asy_sync_period);
      m_active = tdd_enable;
      m_en_d   = tdd_enable;
      void'(pin_hist.pop_front());
      pin_hist.push_back(sync_in);
    end
    cyc++;
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("tdd_sync", {63'd0, tdd_sync}, {63'd0, exp_sync});
    checkOutput("drop_count", {61'd0, sync_drop_count}, 64'(m_drop));
    if (tdd_sync) begin
      pulses++;
      pulse_q.push_back(cyc);
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      sync_soft = 1'b0;
    end
  endtask

  task automatic softPulses(input int n);
    for (int i = 0; i < n; i++) begin
      sync_soft = 1'b1;
      applyStimulus(3);
    end
  endtask

  initial begin
    int e;
    int x;
    int n0;

    // Pin held high across reset must not look like an edge.
    resetn = 1'b0;
    sync_in = 1'b1;
    sync_ext_en = 1'b1;
    tdd_cstate = ARMED;
    applyStimulus(4);
    checkOutput("reset_sync", {63'd0, tdd_sync}, 64'd0);
    checkOutput("reset_drop", {61'd0, sync_drop_count}, 64'd0);
    resetn = 1'b1;
    tdd_enable = 1'b1;
    n0 = pulses;
    applyStimulus(10);
    checkOutput("held_high_no_pulse", 64'(pulses - n0), 64'd0);

    // External rising edge: three cycles through synchronizer and output register.
    sync_in = 1'b0;
    applyStimulus(5);
    x = cyc;
    sync_in = 1'b1;
    pulse_q.delete();
    applyStimulus(8);
    checkOutput("ext_count", 64'(pulse_q.size()), 64'd1);
    if (pulse_q.size() > 0) checkOutput("ext_latency", 64'(pulse_q[0] - x), 64'd3);

    // Software pulse appears the next cycle.
    sync_ext_en = 1'b0;
    x = cyc;
    sync_soft = 1'b1;
    pulse_q.delete();
    applyStimulus(5);
    checkOutput("soft_count", 64'(pulse_q.size()), 64'd1);
    if (pulse_q.size() > 0) checkOutput("soft_latency", 64'(pulse_q[0] - x), 64'd1);
    checkOutput("soft_drop", {61'd0, sync_drop_count}, 64'd0);

    // Internal period 5.
    tdd_enable = 1'b0;
    applyStimulus(2);
    asy_sync_period = 16'd5;
    sync_int_en = 1'b1;
    tdd_enable = 1'b1;
    e = cyc;
    pulse_q.delete();
    applyStimulus(17);
    checkOutput("int_count", 64'(pulse_q.size()), 64'd3);
    if (pulse_q.size() == 3) begin
      checkOutput("int_first", 64'(pulse_q[0] - e), 64'd6);
      checkOutput("int_second", 64'(pulse_q[1] - e), 64'd11);
      checkOutput("int_third", 64'(pulse_q[2] - e), 64'd16);
    end

    // Period 0 keeps the internal source silent.
    tdd_enable = 1'b0;
    applyStimulus(2);
    asy_sync_period = 16'd0;
    tdd_enable = 1'b1;
    n0 = pulses;
    applyStimulus(20);
    checkOutput("p0_silent", 64'(pulses - n0), 64'd0);

    // Gate closed: drops counted; re-sync mode forwards everything.
    sync_int_en = 1'b0;
    tdd_cstate = RUNNING;
    tdd_sync_rst = 1'b0;
    n0 = pulses;
    softPulses(3);
    checkOutput("gated_pulses", 64'(pulses - n0), 64'd0);
    checkOutput("gated_drop3", {61'd0, sync_drop_count}, 64'd3);
    tdd_enable = 1'b0;
    applyStimulus(1);
    tdd_enable = 1'b1;
    applyStimulus(1);
    checkOutput("enable_clear", {61'd0, sync_drop_count}, 64'd0);
    tdd_sync_rst = 1'b1;
    n0 = pulses;
    softPulses(3);
    checkOutput("resync_pulses", 64'(pulses - n0), 64'd3);
    checkOutput("resync_drop", {61'd0, sync_drop_count}, 64'd0);

    // Alignment: ext edge at internal count 3 restarts the phase; soft coincident with int.
    tdd_sync_rst = 1'b0;
    tdd_cstate = ARMED;
    tdd_enable = 1'b0;
    sync_in = 1'b0;
    sync_ext_en = 1'b1;
    sync_int_en = 1'b1;
    asy_sync_period = 16'd8;
    applyStimulus(4);
    tdd_enable = 1'b1;
    e = cyc;
    pulse_q.delete();
    applyStimulus(2);
    sync_in = 1'b1;
    applyStimulus(10);
    sync_soft = 1'b1;
    applyStimulus(10);
    checkOutput("align_count", 64'(pulse_q.size()), 64'd3);
    if (pulse_q.size() == 3) begin
      checkOutput("align_ext", 64'(pulse_q[0] - e), 64'd5);
      checkOutput("align_int", 64'(pulse_q[1] - pulse_q[0]), 64'd8);
      checkOutput("align_next", 64'(pulse_q[2] - pulse_q[1]), 64'd8);
    end

    // Saturation then clear on enable rise.
    sync_ext_en = 1'b0;
    sync_int_en = 1'b0;
    tdd_cstate = RUNNING;
    softPulses(9);
    checkOutput("drop_saturate", {61'd0, sync_drop_count}, 64'(DROP_MAX));
    tdd_enable = 1'b0;
    applyStimulus(1);
    tdd_enable = 1'b1;
    applyStimulus(1);
    checkOutput("sat_clear", {61'd0, sync_drop_count}, 64'd0);

    // Reset mid-period restarts the internal phase.
    tdd_cstate = ARMED;
    sync_int_en = 1'b1;
    asy_sync_period = 16'd5;
    tdd_enable = 1'b0;
    applyStimulus(1);
    tdd_enable = 1'b1;
    applyStimulus(8);
    resetn = 1'b0;
    applyStimulus(1);
    checkOutput("midreset_sync", {63'd0, tdd_sync}, 64'd0);
    resetn = 1'b1;
    x = cyc;
    pulse_q.delete();
    applyStimulus(8);
    checkOutput("restart_count", 64'(pulse_q.size()), 64'd1);
    if (pulse_q.size() > 0) checkOutput("restart_phase", 64'(pulse_q[0] - x), 64'd6);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) tdd_enable = ~tdd_enable;
      if (!tdd_enable && $urandom_range(0, 3) == 0) asy_sync_period = SW'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) sync_in = ~sync_in;
      if ($urandom_range(0, 49) == 0) sync_ext_en = ~sync_ext_en;
      if ($urandom_range(0, 49) == 0) sync_int_en = ~sync_int_en;
      if ($urandom_range(0, 59) == 0) tdd_sync_rst = ~tdd_sync_rst;
      if ($urandom_range(0, 15) == 0)
        tdd_cstate = ($urandom_range(0, 1) == 0) ? ARMED : state_t'($urandom_range(0, 3));
      sync_soft = ($urandom_range(0, 7) == 0);
      applyStimulus(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
